// File: rtl/dspi_pkg.sv
// dspi_pkg: shared definitions for the dual-SPI memory slave slice.
//   arb_state_t      - RAM arbiter FSM states
//   PORT_SPI/PORT_FAB - requester index (0 = DSPI slave, 1 = fabric)
//   DEF_ADDR_W/DEF_DATA_W - default RAM geometry
package dspi_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } arb_state_t;

   localparam logic PORT_SPI = 1'b0;
   localparam logic PORT_FAB = 1'b1;

   localparam int DEF_ADDR_W = 11;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/dspi_mem_arbiter.sv
// dspi_mem_arbiter: shares one single-port block RAM between the DSPI slave
// (port 0, fixed priority) and fabric logic (port 1, bounded starvation).
// Every grant becomes one registered RAM access, acknowledged with read data.
//
// Ports (clk80 domain, rising edge, RST_N async active-low):
//   P0_*/P1_*  requester side: REQ/WE/ADDR/WDATA in, ACK pulse + RDATA out
//   MEM_*      RAM side: EN/WE/ADDR/WDATA out, RDATA in (1-cycle read latency)
//   BUSY       high whenever the FSM is not IDLE
module dspi_mem_arbiter
   import dspi_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_HOLD = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              P0_REQ,
   input  logic              P0_WE,
   input  logic [ADDR_W-1:0] P0_ADDR,
   input  logic [DATA_W-1:0] P0_WDATA,
   output logic              P0_ACK,
   output logic [DATA_W-1:0] P0_RDATA,
   input  logic              P1_REQ,
   input  logic              P1_WE,
   input  logic [ADDR_W-1:0] P1_ADDR,
   input  logic [DATA_W-1:0] P1_WDATA,
   output logic              P1_ACK,
   output logic [DATA_W-1:0] P1_RDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY
);

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   arb_state_t        state;
   logic [3:0]        hold_cnt;
   logic              lat_port;
   logic              lat_we;
   logic [DATA_W-1:0] p0_rdata_q;
   logic [DATA_W-1:0] p1_rdata_q;

   logic              pick_fab;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Port 1 wins only when port 0 is idle or has used up its hold budget.
   always_comb begin
      pick_fab  = P1_REQ && (!P0_REQ || (hold_cnt == HOLD_MAX));
      sel_we    = pick_fab ? P1_WE    : P0_WE;
      sel_addr  = pick_fab ? P1_ADDR  : P0_ADDR;
      sel_wdata = pick_fab ? P1_WDATA : P0_WDATA;
   end

   // RAM read data only lands in the ACK cycle, so it is passed straight
   // through while ACK is high and held from the capture register otherwise.
   always_comb begin
      P0_RDATA = (P0_ACK && !lat_we) ? MEM_RDATA : p0_rdata_q;
      P1_RDATA = (P1_ACK && !lat_we) ? MEM_RDATA : p1_rdata_q;
   end

   // MEM_* are loaded on the granting edge so they are valid throughout the
   // ISSUE state; ACK is loaded on the ISSUE edge so it covers COMPLETE.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         lat_port   <= PORT_SPI;
         lat_we     <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         P0_ACK     <= 1'b0;
         P1_ACK     <= 1'b0;
         MEM_EN     <= 1'b0;
         MEM_WE     <= 1'b0;
         MEM_ADDR   <= '0;
         MEM_WDATA  <= '0;
         BUSY       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!P1_REQ) begin
                  hold_cnt <= '0;
               end
               if (P0_REQ || P1_REQ) begin
                  lat_port  <= pick_fab ? PORT_FAB : PORT_SPI;
                  lat_we    <= sel_we;
                  MEM_EN    <= 1'b1;
                  MEM_WE    <= sel_we;
                  MEM_ADDR  <= sel_addr;
                  MEM_WDATA <= sel_wdata;
                  BUSY      <= 1'b1;
                  state     <= ISSUE;
                  if (pick_fab) begin
                     hold_cnt <= '0;
                  end else if (P1_REQ && (hold_cnt < HOLD_MAX)) begin
                     hold_cnt <= hold_cnt + 4'd1;
                  end
               end
            end
            ISSUE: begin
               MEM_EN <= 1'b0;
               MEM_WE <= 1'b0;
               P0_ACK <= (lat_port == PORT_SPI);
               P1_ACK <= (lat_port == PORT_FAB);
               state  <= COMPLETE;
            end
            COMPLETE: begin
               P0_ACK <= 1'b0;
               P1_ACK <= 1'b0;
               if (!lat_we) begin
                  if (lat_port == PORT_SPI) begin
                     p0_rdata_q <= MEM_RDATA;
                  end else begin
                     p1_rdata_q <= MEM_RDATA;
                  end
               end
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dspi_mem_arbiter.sv
// tb_dspi_mem_arbiter: directed stimulus with a scoreboard. Each test pushes
// the accesses it expects (in expected grant order) and a negedge monitor
// checks every RAM access and every ACK against the queue head.
module tb_dspi_mem_arbiter;

   logic        CLK;
   logic        RST_N;
   logic        P0_REQ, P0_WE, P0_ACK;
   logic [10:0] P0_ADDR;
   logic [7:0]  P0_WDATA, P0_RDATA;
   logic        P1_REQ, P1_WE, P1_ACK;
   logic [10:0] P1_ADDR;
   logic [7:0]  P1_WDATA, P1_RDATA;
   logic        MEM_EN, MEM_WE, BUSY;
   logic [10:0] MEM_ADDR;
   logic [7:0]  MEM_WDATA, MEM_RDATA;

   dspi_mem_arbiter #(.ADDR_W(11), .DATA_W(8), .MAX_HOLD(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
      .P0_ACK(P0_ACK), .P0_RDATA(P0_RDATA),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
      .P1_ACK(P1_ACK), .P1_RDATA(P1_RDATA),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // RAM model: registered read, 1-cycle latency. Contents after reset are
   // addr[7:0] ^ 0x86, so 0x123 -> 0xA5, 0x010 -> 0x96, 0x020 -> 0xA6.
   logic [7:0] ram [0:2047];
   always @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < 2048; i++) begin
            ram[i] <= 8'(i) ^ 8'h86;
         end
      end else if (MEM_EN) begin
         if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
         else        MEM_RDATA <= ram[MEM_ADDR];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_en = -1;
   int en_gap  = 0;
   int p1_wait = 0;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   typedef struct {
      logic       port;
      logic       we;
      logic [10:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input logic port, input logic we, input logic [10:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Monitor: checks each RAM access and each ACK against the queue head.
   initial forever begin
      @(negedge CLK);
      if (RST_N) begin
         if (MEM_EN) begin
            chk("access_expected", 64'(sb.size() != 0), 64'd1);
            chk("busy_in_issue", 64'(BUSY), 64'd1);
            if (sb.size() != 0) begin
               chk("mem_we", 64'(MEM_WE), 64'(sb[0].we));
               chk("mem_addr", 64'(MEM_ADDR), 64'(sb[0].addr));
               if (sb[0].we) chk("mem_wdata", 64'(MEM_WDATA), 64'(sb[0].wdata));
            end
            if (last_en >= 0) begin
               en_gap = cyc - last_en;
               chk("grant_spacing_ge3", 64'(en_gap >= 3), 64'd1);
            end
            last_en = cyc;
         end
         if (P0_ACK || P1_ACK) begin
            chk("single_ack", 64'({P0_ACK, P1_ACK} != 2'b11), 64'd1);
            chk("ack_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_port", 64'(P1_ACK), 64'(e.port));
               chk("ack_latency", 64'(cyc - last_en), 64'd1);
               if (!e.we) begin
                  chk("rdata", 64'(P1_ACK ? P1_RDATA : P0_RDATA), 64'(e.rdata));
               end
            end
         end
         if (P1_ACK) begin
            chk("p1_wait_le15", 64'(p1_wait <= 15), 64'd1);
            p1_wait = 0;
         end else if (P1_REQ) begin
            p1_wait++;
         end
      end
   end

   // Raises one port's REQ with fixed fields and holds it for n ACKs.
   task automatic run_port(input logic p, input int n, input logic we,
                           input logic [10:0] addr, input logic [7:0] wdata,
                           input bit chk_gap);
      int got = 0;
      int t   = 0;
      int last = -1;
      if (p) begin
         P1_WE = we; P1_ADDR = addr; P1_WDATA = wdata; P1_REQ = 1'b1;
      end else begin
         P0_WE = we; P0_ADDR = addr; P0_WDATA = wdata; P0_REQ = 1'b1;
      end
      while (got < n && t < 200) begin
         @(negedge CLK);
         t++;
         if (p ? P1_ACK : P0_ACK) begin
            got++;
            if (chk_gap && last >= 0) chk("held_ack_spacing", 64'(cyc - last), 64'd3);
            last = cyc;
            if (got == n) begin
               if (p) P1_REQ = 1'b0; else P0_REQ = 1'b0;
            end
         end
      end
      chk(p ? "p1_acks_done" : "p0_acks_done", 64'(got), 64'(n));
      if (p) P1_REQ = 1'b0; else P0_REQ = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0;
      P0_REQ = 0; P0_WE = 0; P0_ADDR = '0; P0_WDATA = '0;
      P1_REQ = 0; P1_WE = 0; P1_ADDR = '0; P1_WDATA = '0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", 64'({P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, MEM_EN, MEM_WE,
                                MEM_ADDR, MEM_WDATA, BUSY}), 64'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Reset in the middle of ISSUE of a port-0 write to 0x005.
      P0_WE = 1'b1; P0_ADDR = 11'h005; P0_WDATA = 8'h77; P0_REQ = 1'b1;
      @(posedge CLK);
      #1;
      chk("issue_mem_en", 64'(MEM_EN), 64'd1);
      #1 RST_N = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, MEM_EN, MEM_WE,
                                      MEM_ADDR, MEM_WDATA, BUSY}), 64'd0);
      P0_REQ = 1'b0;
      last_en = -1;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      chk("busy_after_reset", 64'(BUSY), 64'd0);

      // Single read by port 1.
      push(1'b1, 1'b0, 11'h123, 8'h00, 8'hA5);
      run_port(1'b1, 1, 1'b0, 11'h123, 8'h00, 1'b0);
      repeat (3) @(negedge CLK);

      // Port 0 write then read of 0x7FF; read grant 3 cycles after write.
      push(1'b0, 1'b1, 11'h7FF, 8'h3C, 8'h00);
      push(1'b0, 1'b0, 11'h7FF, 8'h00, 8'h3C);
      run_port(1'b0, 1, 1'b1, 11'h7FF, 8'h3C, 1'b0);
      run_port(1'b0, 1, 1'b0, 11'h7FF, 8'h00, 1'b0);
      chk("write_read_gap", 64'(en_gap), 64'd3);
      repeat (3) @(negedge CLK);

      // Simultaneous requests with hold_cnt = 0: port 0 first, then port 1.
      push(1'b0, 1'b1, 11'h040, 8'h5C, 8'h00);
      push(1'b1, 1'b0, 11'h123, 8'h00, 8'hA5);
      fork
         run_port(1'b0, 1, 1'b1, 11'h040, 8'h5C, 1'b0);
         run_port(1'b1, 1, 1'b0, 11'h123, 8'h00, 1'b0);
      join
      repeat (3) @(negedge CLK);

      // Starvation: grant pattern 0,0,0,0,1,0,0,0,0,1 with MAX_HOLD = 4.
      for (int g = 0; g < 10; g++) begin
         if (g == 4 || g == 9) push(1'b1, 1'b0, 11'h020, 8'h00, 8'hA6);
         else                  push(1'b0, 1'b0, 11'h010, 8'h00, 8'h96);
      end
      fork
         run_port(1'b0, 8, 1'b0, 11'h010, 8'h00, 1'b0);
         run_port(1'b1, 2, 1'b0, 11'h020, 8'h00, 1'b0);
      join
      repeat (3) @(negedge CLK);

      // Held REQ: three back-to-back reads, ACKs exactly 3 cycles apart.
      for (int g = 0; g < 3; g++) push(1'b0, 1'b0, 11'h7FF, 8'h00, 8'h3C);
      run_port(1'b0, 3, 1'b0, 11'h7FF, 8'h00, 1'b1);
      repeat (5) @(negedge CLK);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("idle_at_end", 64'(BUSY), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dspi_mem_arbiter.md
# dspi_mem_arbiter

Shares the single-port block RAM behind the dual-SPI memory slave between two requesters: port 0 (the DSPI slave, which receives data from the external host) and port 1 (internal fabric logic). It sits between the DSPI memory core and the RAM in the 80 MHz `clk80` domain. Port 0 has fixed priority, with a bounded-starvation guarantee for port 1. Each granted request becomes exactly one registered RAM access, acknowledged with read data.

## Interface
- `ADDR_W`, 11: RAM address width.
- `DATA_W`, 8: RAM data width.
- `MAX_HOLD`, 4: maximum consecutive port-0 grants while port 1 is waiting (1..15).

- `CLK` in 1: system clock (`clk80`). All logic is on the rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `P0_REQ` / `P1_REQ` in 1: access request. Held high, with its fields stable, until the matching ACK.
- `P0_WE` / `P1_WE` in 1: 1 = write, 0 = read.
- `P0_ADDR` / `P1_ADDR` in ADDR_W: access address.
- `P0_WDATA` / `P1_WDATA` in DATA_W: write data.
- `P0_ACK` / `P1_ACK` out 1: one-cycle pulse marking completion of the access.
- `P0_RDATA` / `P1_RDATA` out DATA_W: read data, valid while ACK is high (held otherwise).
- `MEM_EN` out 1: RAM enable.
- `MEM_WE` out 1: RAM write enable.
- `MEM_ADDR` out ADDR_W: RAM address.
- `MEM_WDATA` out DATA_W: RAM write data.
- `MEM_RDATA` in DATA_W: RAM read data, registered, valid 1 cycle after `MEM_EN`.
- `BUSY` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, COMPLETE.
- **IDLE**
  - No REQ: stay in IDLE.
  - Otherwise pick a winner, latch its WE/ADDR/WDATA and its port index, then go to ISSUE.
- **Winner selection:** port 0 wins, unless `P1_REQ` is high and `hold_cnt == MAX_HOLD`; then port 1 wins.
- **hold_cnt** (4-bit):
  - Increments on a port-0 grant while `P1_REQ` is high.
  - Clears to 0 on a port-1 grant.
  - Clears to 0 in any IDLE cycle with `P1_REQ` low.
  - Saturates at `MAX_HOLD`.
- **ISSUE:** `MEM_EN = 1`; `MEM_WE`, `MEM_ADDR` and `MEM_WDATA` come from the latched values. Go to COMPLETE.
- **COMPLETE**
  - Assert the winner's ACK.
  - On a read, drive and register `MEM_RDATA` onto the winner's RDATA. On a write, RDATA keeps its last value.
  - Go to IDLE.
- Requests are never sampled in ISSUE or COMPLETE, so a REQ still high during its own ACK cycle is not double-counted.
- A requester may deassert REQ in the cycle after ACK, or keep it high to request again. A held REQ is evaluated in the next IDLE cycle.
- A REQ that drops before ACK is a protocol violation. The arbiter still completes the latched access and pulses ACK.
- Simultaneous requests are resolved by the selection rule above. The loser keeps waiting, and no request is ever lost.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, `hold_cnt` is 0, latched fields are 0.
- **Reset mid-access:** the access is aborted immediately (asynchronously) and no ACK is issued. A RAM write in progress at reset may or may not have landed.
- **Access latency:** REQ sampled high in IDLE at edge k → `MEM_EN` high in cycle k+1 → ACK and RDATA valid in cycle k+2.
- **Throughput:** 1 access per 3 cycles. The next grant is made at the IDLE edge k+3.
- **All outputs are registered:** no combinational path from any REQ to ACK or MEM_*.
- **Starvation bound:** with both ports continuously requesting, the grant pattern is `MAX_HOLD` port-0 grants followed by 1 port-1 grant, repeating. Port 1 waits at most `3*(MAX_HOLD+1)` cycles.

## Structure
- Shared package `dspi_pkg`:
  - state enum `arb_state_t` (IDLE, ISSUE, COMPLETE);
  - port index constants `PORT_SPI = 0`, `PORT_FAB = 1`;
  - default width constants for ADDR_W and DATA_W.
- Single module; no sub-module needed. Winner selection and `hold_cnt` live in the same always block as the FSM.

## Test plan
- Reset: assert `RST_N` low mid-ISSUE of a port-0 write to 0x005 → all outputs 0 immediately, no ACK. After release, BUSY = 0.
- Single read: port 1 reads 0x123 holding 0xA5 → `MEM_EN` in cycle k+1 with `MEM_ADDR` = 0x123 and `MEM_WE` = 0. `P1_ACK` in k+2 with `P1_RDATA` = 0xA5; `P0_ACK` never pulses.
- Write then read: port 0 writes 0x3C to 0x7FF, then reads 0x7FF → `MEM_WE` = 1 with `MEM_WDATA` = 0x3C, then the read returns 0x3C. The second grant comes 3 cycles after the first.
- Simultaneous requests: P0 and P1 request in the same cycle with `hold_cnt` = 0 → port 0 is served first, port 1 in the next slot, and both ACKs fire exactly once.
- Starvation: both ports request continuously with `MAX_HOLD` = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1; port-1 wait never exceeds 15 cycles.
- Held REQ: P0_REQ held high across 3 accesses → exactly 3 `P0_ACK` pulses, 3 cycles apart, with no duplicate access in any ACK cycle.
